// File: rtl/id_ex_hazard_stage_pkg.sv
// Shared defaults, constants and the EX control bundle for the ID/EX hazard stage.
`default_nettype none

package id_ex_hazard_stage_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int REG_W_DEF  = 5;
  localparam int ALU_CTRL_W = 4;

  localparam logic [REG_W_DEF-1:0] ZERO_REG = '0;

  typedef struct packed {
    logic                  reg_write;
    logic                  mem_to_reg;
    logic                  mem_write;
    logic                  alu_src;
    logic [ALU_CTRL_W-1:0] alu_control;
  } ex_ctrl_t;

  // A bubble must never write the register file nor memory.
  localparam ex_ctrl_t BUBBLE_CTRL = '0;

endpackage

`default_nettype wire

// File: rtl/id_ex_hazard_stage_hazard_detect.sv
// Load-use and branch-in-ID hazard detection; purely combinational.
`default_nettype none

module hazard_detect
  import id_ex_hazard_stage_pkg::*;
#(
  parameter int REG_W = REG_W_DEF
) (
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             id_uses_rt,
  input  logic             id_branch,
  input  logic [REG_W-1:0] ex_write_reg,
  input  logic             ex_reg_write,
  input  logic             ex_mem_to_reg,
  input  logic [REG_W-1:0] mem_write_reg,
  input  logic             mem_reg_write,
  input  logic             mem_mem_to_reg,
  output logic             load_use,
  output logic             branch_hz
);

  logic ex_match;
  logic mem_match;

  // $0 is hardwired, so a write to it never creates a dependency.
  assign ex_match  = (ex_write_reg != REG_W'(ZERO_REG)) &&
                     ((ex_write_reg == id_rs) || (id_uses_rt && (ex_write_reg == id_rt)));
  assign mem_match = (mem_write_reg != REG_W'(ZERO_REG)) &&
                     ((mem_write_reg == id_rs) || (id_uses_rt && (mem_write_reg == id_rt)));

  assign load_use  = ex_mem_to_reg && ex_reg_write && ex_match;
  assign branch_hz = id_branch && ((ex_reg_write && ex_match) ||
                                   (mem_reg_write && mem_mem_to_reg && mem_match));

endmodule

`default_nettype wire

// File: rtl/id_ex_hazard_stage.sv
// ID/EX pipeline register with stall/bubble control and a consecutive-stall watchdog.
// Optional HAZARD_PERF_EN adds bubble and hold-cycle performance counters.
`default_nettype none

module id_ex_hazard_stage
  import id_ex_hazard_stage_pkg::*;
#(
  parameter int DATA_W    = DATA_W_DEF,
  parameter int REG_W     = REG_W_DEF,
  parameter int CNT_W     = 8,
  parameter int MAX_STALL = 64
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [REG_W-1:0]      ID_RS,
  input  logic [REG_W-1:0]      ID_RT,
  input  logic                  ID_UsesRT,
  input  logic                  ID_Branch,
  input  logic [REG_W-1:0]      ID_WriteReg,
  input  logic                  ID_RegWrite,
  input  logic                  ID_MemtoReg,
  input  logic                  ID_MemWrite,
  input  logic                  ID_ALUSrc,
  input  logic [ALU_CTRL_W-1:0] ID_ALUControl,
  input  logic [DATA_W-1:0]     ID_RD1,
  input  logic [DATA_W-1:0]     ID_RD2,
  input  logic [DATA_W-1:0]     ID_Imm,
  input  logic [REG_W-1:0]      EX_MEM_WriteReg,
  input  logic                  EX_MEM_RegWrite,
  input  logic                  EX_MEM_MemtoReg,
  input  logic                  EX_Hold,
  input  logic                  EX_Flush,
  output logic                  Stall_FD,
  output logic [REG_W-1:0]      EX_RS,
  output logic [REG_W-1:0]      EX_RT,
  output logic [REG_W-1:0]      EX_WriteReg,
  output logic                  EX_RegWrite,
  output logic                  EX_MemtoReg,
  output logic                  EX_MemWrite,
  output logic                  EX_ALUSrc,
  output logic [ALU_CTRL_W-1:0] EX_ALUControl,
  output logic [DATA_W-1:0]     EX_RD1,
  output logic [DATA_W-1:0]     EX_RD2,
  output logic [DATA_W-1:0]     EX_Imm,
  output logic                  Stall_Timeout
`ifdef HAZARD_PERF_EN
  ,
  output logic [31:0]           Perf_Bubbles,
  output logic [31:0]           Perf_HoldCycles
`endif
);

  localparam logic [31:0] MAX_STALL_U = 32'(MAX_STALL);

  logic             load_use;
  logic             branch_hz;
  logic             hazard;
  logic             load_bubble;
  logic             load_id;
  ex_ctrl_t         ex_ctrl;
  ex_ctrl_t         id_ctrl;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] cnt_next;

  hazard_detect #(.REG_W(REG_W)) u_hazard_detect (
    .id_rs          (ID_RS),
    .id_rt          (ID_RT),
    .id_uses_rt     (ID_UsesRT),
    .id_branch      (ID_Branch),
    .ex_write_reg   (EX_WriteReg),
    .ex_reg_write   (EX_RegWrite),
    .ex_mem_to_reg  (EX_MemtoReg),
    .mem_write_reg  (EX_MEM_WriteReg),
    .mem_reg_write  (EX_MEM_RegWrite),
    .mem_mem_to_reg (EX_MEM_MemtoReg),
    .load_use       (load_use),
    .branch_hz      (branch_hz)
  );

  assign hazard   = load_use | branch_hz;
  assign Stall_FD = hazard | EX_Hold;

  // Flush beats hold; a hazard only inserts a bubble when EX is free to advance.
  assign load_bubble = EX_Flush | (~EX_Hold & hazard);
  assign load_id     = ~EX_Flush & ~EX_Hold & ~hazard;

  assign id_ctrl = '{reg_write:   ID_RegWrite,
                     mem_to_reg:  ID_MemtoReg,
                     mem_write:   ID_MemWrite,
                     alu_src:     ID_ALUSrc,
                     alu_control: ID_ALUControl};

  assign EX_RegWrite   = ex_ctrl.reg_write;
  assign EX_MemtoReg   = ex_ctrl.mem_to_reg;
  assign EX_MemWrite   = ex_ctrl.mem_write;
  assign EX_ALUSrc     = ex_ctrl.alu_src;
  assign EX_ALUControl = ex_ctrl.alu_control;

  always_ff @(posedge CLK) begin
    if (RST || load_bubble) begin
      ex_ctrl     <= BUBBLE_CTRL;
      EX_RS       <= '0;
      EX_RT       <= '0;
      EX_WriteReg <= '0;
      EX_RD1      <= '0;
      EX_RD2      <= '0;
      EX_Imm      <= '0;
    end else if (load_id) begin
      ex_ctrl     <= id_ctrl;
      EX_RS       <= ID_RS;
      EX_RT       <= ID_RT;
      EX_WriteReg <= ID_WriteReg;
      EX_RD1      <= ID_RD1;
      EX_RD2      <= ID_RD2;
      EX_Imm      <= ID_Imm;
    end
  end

  always_comb begin
    cnt_next = '0;
    if (Stall_FD) begin
      cnt_next = (stall_cnt == '1) ? stall_cnt : stall_cnt + CNT_W'(1);
    end
  end

  // Timeout is registered alongside the count it is derived from.
  always_ff @(posedge CLK) begin
    if (RST) begin
      stall_cnt     <= '0;
      Stall_Timeout <= 1'b0;
    end else begin
      stall_cnt     <= cnt_next;
      Stall_Timeout <= (32'(cnt_next) >= MAX_STALL_U);
    end
  end

`ifdef HAZARD_PERF_EN
  always_ff @(posedge CLK) begin
    if (RST) begin
      Perf_Bubbles    <= '0;
      Perf_HoldCycles <= '0;
    end else begin
      if (load_bubble) Perf_Bubbles    <= Perf_Bubbles + 32'd1;
      if (EX_Hold)     Perf_HoldCycles <= Perf_HoldCycles + 32'd1;
    end
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_id_ex_hazard_stage.sv
// Randomized and directed bench for id_ex_hazard_stage against a behavioural model.
`default_nettype none

module tb_id_ex_hazard_stage;

  logic        CLK = 1'b0;
  logic        RST;
  logic [4:0]  ID_RS, ID_RT, ID_WriteReg;
  logic        ID_UsesRT, ID_Branch, ID_RegWrite, ID_MemtoReg, ID_MemWrite, ID_ALUSrc;
  logic [3:0]  ID_ALUControl;
  logic [31:0] ID_RD1, ID_RD2, ID_Imm;
  logic [4:0]  EX_MEM_WriteReg;
  logic        EX_MEM_RegWrite, EX_MEM_MemtoReg, EX_Hold, EX_Flush;
  wire         Stall_FD, Stall_Timeout;
  wire  [4:0]  EX_RS, EX_RT, EX_WriteReg;
  wire         EX_RegWrite, EX_MemtoReg, EX_MemWrite, EX_ALUSrc;
  wire  [3:0]  EX_ALUControl;
  wire  [31:0] EX_RD1, EX_RD2, EX_Imm;
`ifdef HAZARD_PERF_EN
  wire  [31:0] Perf_Bubbles, Perf_HoldCycles;
`endif

  always #5 CLK = ~CLK;

  id_ex_hazard_stage #(.DATA_W(32), .REG_W(5), .CNT_W(8), .MAX_STALL(4)) dut (
    .CLK(CLK), .RST(RST),
    .ID_RS(ID_RS), .ID_RT(ID_RT), .ID_UsesRT(ID_UsesRT), .ID_Branch(ID_Branch),
    .ID_WriteReg(ID_WriteReg), .ID_RegWrite(ID_RegWrite), .ID_MemtoReg(ID_MemtoReg),
    .ID_MemWrite(ID_MemWrite), .ID_ALUSrc(ID_ALUSrc), .ID_ALUControl(ID_ALUControl),
    .ID_RD1(ID_RD1), .ID_RD2(ID_RD2), .ID_Imm(ID_Imm),
    .EX_MEM_WriteReg(EX_MEM_WriteReg), .EX_MEM_RegWrite(EX_MEM_RegWrite),
    .EX_MEM_MemtoReg(EX_MEM_MemtoReg), .EX_Hold(EX_Hold), .EX_Flush(EX_Flush),
    .Stall_FD(Stall_FD), .EX_RS(EX_RS), .EX_RT(EX_RT), .EX_WriteReg(EX_WriteReg),
    .EX_RegWrite(EX_RegWrite), .EX_MemtoReg(EX_MemtoReg), .EX_MemWrite(EX_MemWrite),
    .EX_ALUSrc(EX_ALUSrc), .EX_ALUControl(EX_ALUControl),
    .EX_RD1(EX_RD1), .EX_RD2(EX_RD2), .EX_Imm(EX_Imm), .Stall_Timeout(Stall_Timeout)
`ifdef HAZARD_PERF_EN
    , .Perf_Bubbles(Perf_Bubbles), .Perf_HoldCycles(Perf_HoldCycles)
`endif
  );

  typedef struct {
    logic [4:0]  rs, rt, wr;
    logic        rw, m2r, mw, as;
    logic [3:0]  alu;
    logic [31:0] rd1, rd2, imm;
  } ex_t;

  ex_t         m_ex;
  int          m_cnt;
  logic        m_timeout;
  logic [31:0] m_bub, m_hold;
  int          n_checks = 0;
  int          n_errors = 0;
  logic        last_stall;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic bit reads(input logic [4:0] r);
    return (r != 0) && ((r == ID_RS) || (ID_UsesRT && r == ID_RT));
  endfunction

  // One clock: check Stall_FD before the edge, advance the model, check registers after.
  task automatic tick();
    bit hz, stall;
    ex_t nxt;
    @(negedge CLK);
    hz = (m_ex.rw && m_ex.m2r && reads(m_ex.wr)) ||
         (ID_Branch && ((m_ex.rw && reads(m_ex.wr)) ||
                        (EX_MEM_RegWrite && EX_MEM_MemtoReg && reads(EX_MEM_WriteReg))));
    stall = hz || EX_Hold;
    check_val("stall_fd", {63'd0, Stall_FD}, {63'd0, stall});
    last_stall = Stall_FD;
    nxt = m_ex;
    if (RST || EX_Flush || (!EX_Hold && hz)) nxt = '{default: 0};
    else if (!EX_Hold)
      nxt = '{rs: ID_RS, rt: ID_RT, wr: ID_WriteReg, rw: ID_RegWrite, m2r: ID_MemtoReg,
              mw: ID_MemWrite, as: ID_ALUSrc, alu: ID_ALUControl,
              rd1: ID_RD1, rd2: ID_RD2, imm: ID_Imm};
    if (RST) begin
      m_cnt = 0; m_bub = 0; m_hold = 0;
    end else begin
      m_cnt = stall ? ((m_cnt < 255) ? m_cnt + 1 : 255) : 0;
      if (EX_Flush || (!EX_Hold && hz)) m_bub++;
      if (EX_Hold) m_hold++;
    end
    m_timeout = (m_cnt >= 4);
    m_ex = nxt;
    @(posedge CLK);
    #1;
    check_val("ex_rs", 64'(EX_RS), 64'(m_ex.rs));
    check_val("ex_rt", 64'(EX_RT), 64'(m_ex.rt));
    check_val("ex_wr", 64'(EX_WriteReg), 64'(m_ex.wr));
    check_val("ex_ctrl", {56'd0, EX_RegWrite, EX_MemtoReg, EX_MemWrite, EX_ALUSrc, EX_ALUControl},
              {56'd0, m_ex.rw, m_ex.m2r, m_ex.mw, m_ex.as, m_ex.alu});
    check_val("ex_rd", {EX_RD1, EX_RD2}, {m_ex.rd1, m_ex.rd2});
    check_val("ex_imm", 64'(EX_Imm), 64'(m_ex.imm));
    check_val("timeout", 64'(Stall_Timeout), 64'(m_timeout));
`ifdef HAZARD_PERF_EN
    check_val("perf", {Perf_Bubbles, Perf_HoldCycles}, {m_bub, m_hold});
`endif
  endtask

  task automatic set_nop();
    {ID_RS, ID_RT, ID_WriteReg} = '0;
    {ID_UsesRT, ID_Branch, ID_RegWrite, ID_MemtoReg, ID_MemWrite, ID_ALUSrc} = '0;
    ID_ALUControl = 4'd0;
    ID_RD1 = $urandom; ID_RD2 = $urandom; ID_Imm = $urandom;
    EX_MEM_WriteReg = 0; EX_MEM_RegWrite = 0; EX_MEM_MemtoReg = 0;
    EX_Hold = 0; EX_Flush = 0; RST = 0;
  endtask

  task automatic set_lw(input logic [4:0] wr);
    set_nop();
    ID_WriteReg = wr; ID_RegWrite = 1; ID_MemtoReg = 1; ID_ALUSrc = 1; ID_ALUControl = 4'd2;
  endtask

  task automatic set_alu(input logic [4:0] rs, input logic [4:0] rt, input logic use_rt,
                         input logic [4:0] wr);
    set_nop();
    ID_RS = rs; ID_RT = rt; ID_UsesRT = use_rt; ID_WriteReg = wr; ID_RegWrite = 1;
    ID_ALUControl = 4'd2;
  endtask

  task automatic set_beq(input logic [4:0] rs);
    set_nop();
    ID_RS = rs; ID_RT = 5'd0; ID_UsesRT = 1; ID_Branch = 1; ID_ALUControl = 4'd6;
  endtask

  initial begin
    int stalls;
    m_ex = '{default: 0}; m_cnt = 0; m_timeout = 0; m_bub = 0; m_hold = 0;
    set_nop();
    RST = 1;
    tick(); tick();

    // load-use: lw $8 then add reading $8
    set_lw(5'd8); tick();
    set_alu(5'd8, 5'd0, 1'b1, 5'd10); stalls = 0;
    tick(); stalls += int'(last_stall);
    tick(); stalls += int'(last_stall);
    check_val("ld_use_stalls", 64'(stalls), 64'd1);
    check_val("ld_use_loaded", 64'(EX_WriteReg), 64'd10);

    // branch on ALU result: one stall
    set_alu(5'd1, 5'd2, 1'b1, 5'd9); tick();
    set_beq(5'd9); stalls = 0;
    tick(); stalls += int'(last_stall);
    EX_MEM_WriteReg = 5'd9; EX_MEM_RegWrite = 1;
    tick(); stalls += int'(last_stall);
    check_val("br_alu_stalls", 64'(stalls), 64'd1);

    // branch on load result: two stalls, second from EX/MEM
    set_lw(5'd9); tick();
    set_beq(5'd9); stalls = 0;
    tick(); stalls += int'(last_stall);
    EX_MEM_WriteReg = 5'd9; EX_MEM_RegWrite = 1; EX_MEM_MemtoReg = 1;
    tick(); stalls += int'(last_stall);
    EX_MEM_RegWrite = 0; EX_MEM_MemtoReg = 0;
    tick(); stalls += int'(last_stall);
    check_val("br_ld_stalls", 64'(stalls), 64'd2);

    // rt ignored when unused; $0 never a hazard
    set_lw(5'd5); tick();
    set_alu(5'd1, 5'd5, 1'b0, 5'd3); tick();
    check_val("no_rt_stall", 64'(last_stall), 64'd0);
    set_lw(5'd0); tick();
    set_alu(5'd0, 5'd0, 1'b1, 5'd3); tick();
    check_val("zero_reg_stall", 64'(last_stall), 64'd0);

    // hold freezes EX while ID changes; hold+flush gives a bubble
    set_alu(5'd2, 5'd3, 1'b1, 5'd4); tick();
    for (int i = 0; i < 3; i++) begin
      set_alu(5'(i + 11), 5'(i + 12), 1'b1, 5'(i + 13)); EX_Hold = 1; tick();
    end
    check_val("hold_frozen", 64'(EX_WriteReg), 64'd4);
    EX_Flush = 1; tick();
    check_val("hold_flush_bubble", 64'(EX_RegWrite), 64'd0);

    // timeout after four consecutive stall cycles
    set_lw(5'd8); tick();
    set_alu(5'd8, 5'd0, 1'b1, 5'd7); EX_Hold = 1;
    for (int i = 0; i < 3; i++) tick();
    check_val("timeout_early", 64'(Stall_Timeout), 64'd0);
    tick();
    check_val("timeout_rise", 64'(Stall_Timeout), 64'd1);
    EX_Hold = 0; tick();
    tick();
    check_val("timeout_clear", 64'(Stall_Timeout), 64'd0);

    // reset in the middle of a stall
    set_lw(5'd8); tick();
    set_alu(5'd8, 5'd0, 1'b1, 5'd7); EX_Hold = 1; tick(); tick();
    RST = 1; tick();
    check_val("rst_mid_stall", 64'(EX_WriteReg | 5'(EX_RegWrite)), 64'd0);

    // randomized traffic on a small register set to provoke matches
    for (int i = 0; i < 600; i++) begin
      ID_RS = 5'($urandom_range(0, 3)); ID_RT = 5'($urandom_range(0, 3));
      ID_WriteReg = 5'($urandom_range(0, 3));
      ID_UsesRT = 1'($urandom); ID_Branch = ($urandom_range(0, 3) == 0);
      ID_RegWrite = 1'($urandom); ID_MemtoReg = 1'($urandom);
      ID_MemWrite = 1'($urandom); ID_ALUSrc = 1'($urandom); ID_ALUControl = 4'($urandom);
      ID_RD1 = $urandom; ID_RD2 = $urandom; ID_Imm = $urandom;
      EX_MEM_WriteReg = 5'($urandom_range(0, 3));
      EX_MEM_RegWrite = 1'($urandom); EX_MEM_MemtoReg = 1'($urandom);
      EX_Hold = ($urandom_range(0, 5) == 0); EX_Flush = ($urandom_range(0, 9) == 0);
      RST = ($urandom_range(0, 49) == 0);
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
